cache_ctrl_wb: RTL

Parametrised direct-mapped cache controller between the CPU port and the SDRAM controller. It generalises line count, line size and data width, and adds two things:
- dirty-line write-back, or selectable write-through/no-allocate mode;
- an ack-based SDRAM handshake, so memory latency may vary.

Tag, valid and dirty state live in registers; line data lives in a sub-module RAM.

---
 rtl/cache_pkg.sv | 24 ++
 rtl/cache_data_ram.sv | 22 ++
 rtl/cache_ctrl_wb.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared state encoding and geometry helpers for the direct-mapped cache controller.
package cache_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOOKUP  = 3'd1;
   localparam logic [2:0] ST_RESPOND = 3'd2;
   localparam logic [2:0] ST_WB      = 3'd3;
   localparam logic [2:0] ST_FILL    = 3'd4;
   localparam logic [2:0] ST_WT      = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_LOOKUP  = ST_LOOKUP,
      S_RESPOND = ST_RESPOND,
      S_WB      = ST_WB,
      S_FILL    = ST_FILL,
      S_WT      = ST_WT
   } state_t;

   function automatic int tag_width(input int addr_w, input int index_b, input int offset_b);
      return addr_w - index_b - offset_b;
   endfunction

endpackage

// File: rtl/cache_data_ram.sv
// Single-port line-data store: synchronous write, registered read, contents not reset.
module cache_data_ram #(
   parameter int ADDR_BITS  = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_BITS-1:0]  addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/cache_ctrl_wb.sv
// Direct-mapped cache controller with write-back or write-through policy and an
// ack-based per-word SDRAM handshake.
module cache_ctrl_wb
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 8,
   parameter int INDEX_BITS  = 3,
   parameter int OFFSET_BITS = 5,
   parameter int WRITE_BACK  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] Address_cpu,
   input  logic [DATA_WIDTH-1:0] DOut_cpu,
   output logic [DATA_WIDTH-1:0] Din_cpu,
   input  logic                  wr_rd_cpu,
   input  logic                  cs_cpu,
   output logic                  rdy_cpu,
   output logic                  hit,
   output logic [ADDR_WIDTH-1:0] Address_sdram,
   output logic [DATA_WIDTH-1:0] DOut_sdram,
   input  logic [DATA_WIDTH-1:0] Din_sdram,
   output logic                  wr_rd_sdram,
   output logic                  mstrb_sdram,
   input  logic                  ack_sdram
);

   localparam int TAG_W  = tag_width(ADDR_WIDTH, INDEX_BITS, OFFSET_BITS);
   localparam int LINES  = 1 << INDEX_BITS;
   localparam int RAM_AW = INDEX_BITS + OFFSET_BITS;

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] req_addr_reg;
   logic [DATA_WIDTH-1:0] req_data_reg;
   logic                  req_wr_reg;
   logic [OFFSET_BITS-1:0] cnt_reg, cnt_next;
   logic                  gap_reg, gap_next;
   logic                  mstrb_reg, mstrb_next;
   logic [ADDR_WIDTH-1:0] sd_addr_reg, sd_addr_next;
   logic [DATA_WIDTH-1:0] sd_dout_reg, sd_dout_next;
   logic                  sd_wr_reg, sd_wr_next;
   logic                  hit_reg, hit_next;
   logic [DATA_WIDTH-1:0] dout_reg, dout_next;
   logic [DATA_WIDTH-1:0] fill_word_reg, fill_word_next;
   logic                  from_fill_reg, from_fill_next;
   logic [LINES-1:0]      valid_reg, valid_next;
   logic [LINES-1:0]      dirty_reg, dirty_next;
   logic [TAG_W-1:0]      tag_arr [0:LINES-1];
   logic                  tag_we;

   logic                  ram_we;
   logic [RAM_AW-1:0]     ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] ram_rdata;

   logic [TAG_W-1:0]       req_tag;
   logic [INDEX_BITS-1:0]  req_idx;
   logic [OFFSET_BITS-1:0] req_off;
   logic                   lookup_hit;

   assign req_tag    = req_addr_reg[ADDR_WIDTH-1 -: TAG_W];
   assign req_idx    = req_addr_reg[OFFSET_BITS +: INDEX_BITS];
   assign req_off    = req_addr_reg[OFFSET_BITS-1:0];
   assign lookup_hit = valid_reg[req_idx] && (tag_arr[req_idx] == req_tag);

   assign rdy_cpu       = (state_reg == S_IDLE);
   assign hit           = hit_reg;
   assign Din_cpu       = dout_reg;
   assign Address_sdram = sd_addr_reg;
   assign DOut_sdram    = sd_dout_reg;
   assign wr_rd_sdram   = sd_wr_reg;
   assign mstrb_sdram   = mstrb_reg;

   cache_data_ram #(
      .ADDR_BITS  (RAM_AW),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      gap_next       = gap_reg;
      mstrb_next     = mstrb_reg;
      sd_addr_next   = sd_addr_reg;
      sd_dout_next   = sd_dout_reg;
      sd_wr_next     = sd_wr_reg;
      hit_next       = hit_reg;
      dout_next      = dout_reg;
      fill_word_next = fill_word_reg;
      from_fill_next = from_fill_reg;
      valid_next     = valid_reg;
      dirty_next     = dirty_reg;
      tag_we         = 1'b0;
      ram_we         = 1'b0;
      ram_addr       = {req_idx, req_off};
      ram_wdata      = req_data_reg;

      case (state_reg)
         S_IDLE: begin
            if (cs_cpu) begin
               state_next = S_LOOKUP;
            end
         end

         S_LOOKUP: begin
            hit_next       = lookup_hit;
            from_fill_next = 1'b0;
            cnt_next       = '0;
            gap_next       = 1'b0;
            if (lookup_hit) begin
               if (req_wr_reg) begin
                  ram_we = 1'b1;
                  if (WRITE_BACK != 0) begin
                     dirty_next[req_idx] = 1'b1;
                     state_next          = S_RESPOND;
                  end else begin
                     state_next = S_WT;
                  end
               end else begin
                  state_next = S_RESPOND;
               end
            end else if (req_wr_reg && (WRITE_BACK == 0)) begin
               state_next = S_WT;
            end else if (valid_reg[req_idx] && dirty_reg[req_idx]) begin
               state_next = S_WB;
            end else begin
               valid_next[req_idx] = 1'b0;
               state_next          = S_FILL;
            end
         end

         S_WB, S_FILL, S_WT: begin
            if (state_reg != S_WT) begin
               ram_addr = {req_idx, cnt_reg};
            end
            // Two idle cycles per word: the first addresses the RAM, the second
            // sees its registered read data and launches the strobe.
            if (!mstrb_reg) begin
               if (!gap_reg) begin
                  gap_next = 1'b1;
               end else begin
                  gap_next   = 1'b0;
                  mstrb_next = 1'b1;
                  if (state_reg == S_WB) begin
                     sd_addr_next = {tag_arr[req_idx], req_idx, cnt_reg};
                     sd_dout_next = ram_rdata;
                     sd_wr_next   = 1'b1;
                  end else if (state_reg == S_FILL) begin
                     sd_addr_next = {req_tag, req_idx, cnt_reg};
                     sd_dout_next = '0;
                     sd_wr_next   = 1'b0;
                  end else begin
                     sd_addr_next = req_addr_reg;
                     sd_dout_next = req_data_reg;
                     sd_wr_next   = 1'b1;
                  end
               end
            end else if (ack_sdram) begin
               mstrb_next = 1'b0;
               cnt_next   = cnt_reg + 1'b1;
               if (state_reg == S_FILL) begin
                  ram_we    = 1'b1;
                  ram_wdata = Din_sdram;
                  if (cnt_reg == req_off) begin
                     fill_word_next = Din_sdram;
                  end
               end
               if (state_reg == S_WT) begin
                  state_next = S_RESPOND;
               end else if (cnt_reg == '1) begin
                  if (state_reg == S_WB) begin
                     dirty_next[req_idx] = 1'b0;
                     valid_next[req_idx] = 1'b0;
                     state_next          = S_FILL;
                  end else begin
                     tag_we              = 1'b1;
                     valid_next[req_idx] = 1'b1;
                     from_fill_next      = 1'b1;
                     state_next          = S_RESPOND;
                  end
               end
            end
         end

         S_RESPOND: begin
            // A write that missed and allocated merges its word after the fill.
            if (req_wr_reg) begin
               if (from_fill_reg) begin
                  ram_we              = 1'b1;
                  dirty_next[req_idx] = 1'b1;
               end
            end else begin
               dout_next = from_fill_reg ? fill_word_reg : ram_rdata;
            end
            state_next = S_IDLE;
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= S_IDLE;
         req_addr_reg  <= '0;
         req_data_reg  <= '0;
         req_wr_reg    <= 1'b0;
         cnt_reg       <= '0;
         gap_reg       <= 1'b0;
         mstrb_reg     <= 1'b0;
         sd_addr_reg   <= '0;
         sd_dout_reg   <= '0;
         sd_wr_reg     <= 1'b0;
         hit_reg       <= 1'b0;
         dout_reg      <= '0;
         fill_word_reg <= '0;
         from_fill_reg <= 1'b0;
         valid_reg     <= '0;
         dirty_reg     <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         gap_reg       <= gap_next;
         mstrb_reg     <= mstrb_next;
         sd_addr_reg   <= sd_addr_next;
         sd_dout_reg   <= sd_dout_next;
         sd_wr_reg     <= sd_wr_next;
         hit_reg       <= hit_next;
         dout_reg      <= dout_next;
         fill_word_reg <= fill_word_next;
         from_fill_reg <= from_fill_next;
         valid_reg     <= valid_next;
         dirty_reg     <= dirty_next;
         if ((state_reg == S_IDLE) && cs_cpu) begin
            req_addr_reg <= Address_cpu;
            req_data_reg <= DOut_cpu;
            req_wr_reg   <= wr_rd_cpu;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (tag_we) begin
         tag_arr[req_idx] <= req_tag;
      end
   end

endmodule
